// File: rtl/gamepad_scan.sv
// rtl/gamepad_scan.sv - SNES-style serial gamepad scan engine
// Drives latch/clock/select to the pads and commits all button fields at once per frame.
module gamepad_scan #(
  parameter int DIV        = 150,
  parameter int SEL_WIDTH  = 1,
  parameter int DATA_WIDTH = 2,
  parameter int REG_WIDTH  = 12,
  localparam int SW = (SEL_WIDTH > 0) ? SEL_WIDTH : 1,
  localparam int N  = DATA_WIDTH << SEL_WIDTH,
  localparam int VL = N * REG_WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [SW-1:0]         gp_sel,
  input  logic [DATA_WIDTH-1:0] gp_data,
  output logic                  gp_latch,
  output logic                  gp_clk,
  output logic [VL:0]           gp_value,
  output logic                  gp_update,
  input  logic                  ctrl_run
);

  localparam int CW    = $clog2(DIV);
  localparam int KW    = (REG_WIDTH > 1) ? $clog2(REG_WIDTH) : 1;
  localparam int NBANK = 1 << SEL_WIDTH;
  localparam logic [SW-1:0] LAST_SEL = SW'(NBANK - 1);
  localparam logic [KW-1:0] LAST_K   = KW'(REG_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, LATCH, SETTLE, LOW, HIGH} state_t;

  state_t                state;
  logic [CW-1:0]         count;
  logic                  tick;
  logic [KW-1:0]         k;
  logic                  phase;
  logic [DATA_WIDTH-1:0] sync_a;
  logic [DATA_WIDTH-1:0] sync_b;
  logic                  cap_en;
  logic [VL:0]           cap;

  assign tick   = (count == CW'(DIV - 1));
  assign cap_en = tick && (state == LOW);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  // Idle pad lines read high (released), so the synchronizer resets to ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= '1;
      sync_b <= '1;
    end else begin
      sync_a <= gp_data;
      sync_b <= sync_a;
    end
  end

  // Each pad field shifts in from the top so the first sample ends up in bit 0.
  for (genvar s = 0; s < NBANK; s++) begin : g_bank
    for (genvar d = 0; d < DATA_WIDTH; d++) begin : g_line
      logic [REG_WIDTH-1:0] field;
      always_ff @(posedge clk) begin
        if (rst) begin
          field <= '0;
        end else if (cap_en && (gp_sel == SW'(s))) begin
          field <= {~sync_b[d], field[REG_WIDTH-1:1]};
        end
      end
      assign cap[(s*DATA_WIDTH + d)*REG_WIDTH +: REG_WIDTH] = field;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gp_sel    <= '0;
      k         <= '0;
      phase     <= 1'b0;
      gp_latch  <= 1'b0;
      gp_clk    <= 1'b1;
      gp_value  <= '0;
      gp_update <= 1'b0;
    end else begin
      gp_update <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (ctrl_run) begin
              state    <= LATCH;
              gp_sel   <= '0;
              k        <= '0;
              phase    <= 1'b0;
              gp_latch <= 1'b1;
            end
          end
          LATCH: begin
            if (phase) begin
              phase    <= 1'b0;
              state    <= SETTLE;
              gp_latch <= 1'b0;
            end else begin
              phase <= 1'b1;
            end
          end
          SETTLE: begin
            state  <= LOW;
            gp_clk <= 1'b0;
          end
          LOW: begin
            state  <= HIGH;
            gp_clk <= 1'b1;
          end
          HIGH: begin
            if (k != LAST_K) begin
              k      <= k + KW'(1);
              state  <= LOW;
              gp_clk <= 1'b0;
            end else if (gp_sel != LAST_SEL) begin
              gp_sel   <= gp_sel + SW'(1);
              k        <= '0;
              state    <= LATCH;
              gp_latch <= 1'b1;
            end else begin
              gp_value  <= cap;
              gp_update <= 1'b1;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gamepad_scan.sv
// tb/tb_gamepad_scan.sv - directed bench for gamepad_scan with behavioural SNES pads
// Expected frames are queued when pad patterns are set and popped on each gp_update.
module tb_gamepad_scan;

  localparam int DIV = 4;
  localparam int PERIOD = 220;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:0]  gp_sel;
  logic [1:0]  gp_data;
  logic        gp_latch;
  logic        gp_clk;
  logic [47:0] gp_value;
  logic        gp_update;
  logic        ctrl_run;

  gamepad_scan #(.DIV(DIV), .SEL_WIDTH(1), .DATA_WIDTH(2), .REG_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .gp_sel(gp_sel), .gp_data(gp_data), .gp_latch(gp_latch),
    .gp_clk(gp_clk), .gp_value(gp_value), .gp_update(gp_update), .ctrl_run(ctrl_run)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pad p = sel*2 + d; loads while latch is high, shifts toward bit 0 on gp_clk rise.
  logic [11:0] pat [4];
  logic [11:0] sh [4];
  logic        gp_clk_q;
  always @(posedge clk) begin
    gp_clk_q <= gp_clk;
    for (int p = 0; p < 4; p++) begin
      if (rst) sh[p] <= '0;
      else if (gp_latch) sh[p] <= pat[p];
      else if (gp_clk && !gp_clk_q) sh[p] <= {1'b0, sh[p][11:1]};
    end
  end
  always_comb begin
    gp_data = '1;
    for (int d = 0; d < 2; d++) gp_data[d] = ~sh[int'(gp_sel) * 2 + d][0];
  end

  int checks = 0;
  int errors = 0;
  logic [47:0] exp_q [$];
  logic [47:0] committed = '0;
  int last_upd = 0;
  int intv = 0;
  int unstable, rises;
  int falls [2];
  logic [0:0] sel_rise [2];
  logic [0:0] sel_before [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] pack4(input logic [11:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic set_pats(input logic [11:0] a0, a1, a2, a3);
    pat[0] = a0; pat[1] = a1; pat[2] = a2; pat[3] = a3;
  endtask

  task automatic clear_mon();
    unstable = 0; rises = 0; falls[0] = 0; falls[1] = 0;
    sel_rise[0] = '0; sel_rise[1] = '0; sel_before[0] = '0; sel_before[1] = '0;
  endtask

  task automatic wait_update(input int budget, output bit got);
    logic pc, pl;
    logic [0:0] ps;
    got = 1'b0;
    pc = gp_clk; pl = gp_latch; ps = gp_sel;
    for (int n = 0; n < budget && !got; n++) begin
      @(negedge clk);
      if (gp_update === 1'b1) got = 1'b1;
      else if (gp_value !== committed) unstable++;
      if (pc && !gp_clk) falls[gp_sel]++;
      if (!pl && gp_latch) begin
        if (rises < 2) begin
          sel_rise[rises] = gp_sel;
          sel_before[rises] = ps;
        end
        rises++;
      end
      pc = gp_clk; pl = gp_latch; ps = gp_sel;
    end
  endtask

  task automatic expect_frame(input string tag, input int budget);
    bit got;
    logic [47:0] e;
    wait_update(budget, got);
    chk({tag, " update seen"}, 64'(got), 64'd1);
    chk({tag, " queue nonempty"}, 64'(exp_q.size() != 0), 64'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    if (got) begin
      chk({tag, " value"}, gp_value, e);
      intv = cyc - last_upd;
      last_upd = cyc;
      committed = e;
      @(negedge clk);
      chk({tag, " update one cycle"}, 64'(gp_update), 64'd0);
    end
  endtask

  initial begin
    bit got;
    int bl, bc, bs, bv, bu;
    rst = 1'b1;
    ctrl_run = 1'b0;
    set_pats(12'h000, 12'h000, 12'h000, 12'h000);
    repeat (5) @(negedge clk);
    chk("reset sel", 64'(gp_sel), 64'd0);
    chk("reset latch", 64'(gp_latch), 64'd0);
    chk("reset clk", 64'(gp_clk), 64'd1);
    chk("reset value", 64'(gp_value), 64'd0);
    chk("reset update", 64'(gp_update), 64'd0);
    rst = 1'b0;

    // Idle with ctrl_run low
    bl = 0; bc = 0; bs = 0; bv = 0; bu = 0;
    repeat (1000) begin
      @(negedge clk);
      if (gp_latch !== 1'b0) bl++;
      if (gp_clk !== 1'b1) bc++;
      if (gp_sel !== 1'b0) bs++;
      if (gp_value !== 48'h0) bv++;
      if (gp_update !== 1'b0) bu++;
    end
    chk("idle latch cycles", 64'(bl), 64'd0);
    chk("idle clk cycles", 64'(bc), 64'd0);
    chk("idle sel cycles", 64'(bs), 64'd0);
    chk("idle value cycles", 64'(bv), 64'd0);
    chk("idle update cycles", 64'(bu), 64'd0);

    // Single bit on pad 0
    set_pats(12'h001, 12'h000, 12'h000, 12'h000);
    exp_q.push_back(pack4(12'h001, 12'h000, 12'h000, 12'h000));
    exp_q.push_back(pack4(12'h001, 12'h000, 12'h000, 12'h000));
    ctrl_run = 1'b1;
    clear_mon();
    expect_frame("t2 f1", 400);
    expect_frame("t2 f2", 400);
    chk("t2 period", 64'(intv), 64'(PERIOD));

    // Pad mapping, clock pulse count and select timing
    set_pats(12'hA5A, 12'h5A5, 12'hFFF, 12'h000);
    exp_q.push_back(48'h000FFF5A5A5A);
    clear_mon();
    expect_frame("t3", 400);
    chk("t3 period", 64'(intv), 64'(PERIOD));
    chk("t3 bank0 clk pulses", 64'(falls[0]), 64'd12);
    chk("t3 bank1 clk pulses", 64'(falls[1]), 64'd12);
    chk("t3 latch rises", 64'(rises), 64'd2);
    chk("t3 sel held in idle", 64'(sel_before[0]), 64'd1);
    chk("t3 sel at rise0", 64'(sel_rise[0]), 64'd0);
    chk("t3 sel before rise1", 64'(sel_before[1]), 64'd0);
    chk("t3 sel at rise1", 64'(sel_rise[1]), 64'd1);
    chk("t3 stable", 64'(unstable), 64'd0);

    // Patterns change between the two bank latches of one frame
    clear_mon();
    wait_update(58, got);
    chk("t4 no early update", 64'(got), 64'd0);
    set_pats(12'h123, 12'h456, 12'h789, 12'hABC);
    exp_q.push_back(pack4(12'hA5A, 12'h5A5, 12'h789, 12'hABC));
    expect_frame("t4 mixed", 400);
    chk("t4 period", 64'(intv), 64'(PERIOD));
    chk("t4 stable", 64'(unstable), 64'd0);
    exp_q.push_back(pack4(12'h123, 12'h456, 12'h789, 12'hABC));
    clear_mon();
    expect_frame("t4 new", 400);
    chk("t4 new period", 64'(intv), 64'(PERIOD));
    chk("t4 new stable", 64'(unstable), 64'd0);

    // Drop ctrl_run 10 ticks into a frame
    repeat (42) @(negedge clk);
    ctrl_run = 1'b0;
    exp_q.push_back(pack4(12'h123, 12'h456, 12'h789, 12'hABC));
    clear_mon();
    expect_frame("t5", 400);
    chk("t5 period", 64'(intv), 64'(PERIOD));
    bl = 0; bc = 0; bu = 0;
    repeat (600) begin
      @(negedge clk);
      if (gp_latch !== 1'b0) bl++;
      if (gp_clk !== 1'b1) bc++;
      if (gp_update !== 1'b0) bu++;
    end
    chk("t5 idle latch", 64'(bl), 64'd0);
    chk("t5 idle clk", 64'(bc), 64'd0);
    chk("t5 idle update", 64'(bu), 64'd0);

    // Reset during a LOW phase
    set_pats(12'h800, 12'h003, 12'h0F0, 12'h00F);
    ctrl_run = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      if (gp_clk === 1'b0) got = 1'b1;
    end
    chk("t6 reached low", 64'(got), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6 rst clk", 64'(gp_clk), 64'd1);
    chk("t6 rst latch", 64'(gp_latch), 64'd0);
    chk("t6 rst sel", 64'(gp_sel), 64'd0);
    chk("t6 rst value", 64'(gp_value), 64'd0);
    chk("t6 rst update", 64'(gp_update), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    committed = '0;
    exp_q.push_back(pack4(12'h800, 12'h003, 12'h0F0, 12'h00F));
    clear_mon();
    expect_frame("t6 after reset", 400);
    chk("t6 stable", 64'(unstable), 64'd0);
    ctrl_run = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
